alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Iterative shift-add multiply sequencer that drives the shared 64-bit ALU (A, B, cntrl in; result, carry_out out) to compute an unsigned 64x64 -> low-64 product.
- Sits beside the ALU in the execute stage. While busy it owns the ALU input mux; the stall logic holds the pipeline until done.
- Performs one ALU add per cycle and terminates early when no multiplier bits remain.

Parameters:
- WIDTH, 64, operand/product width; must match ALU width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand; captured on accept.
- op_b  in  WIDTH  multiplier; captured on accept.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- product  out  WIDTH  low WIDTH bits of op_a*op_b; held stable from DONE until the next accept.
- mul_ovf  out  1  high if the true 2*WIDTH-bit product does not fit in WIDTH bits; valid with product.
- alu_a  out  WIDTH  driven to ALU A.
- alu_b  out  WIDTH  driven to ALU B.
- alu_cntrl  out  3  driven to ALU cntrl.
- alu_result  in  WIDTH  from ALU result.
- alu_carry_out  in  1  from ALU carry_out.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, product=0, mul_ovf=0. Internal acc, mcand, mplier and cnt all 0. A reset mid-operation aborts immediately with no done pulse.
- ALU drive:
  - alu_cntrl = 3'b010 (ADD) always.
  - alu_a = acc.
  - alu_b = mplier[0] ? mcand : 0 in RUN; 0 otherwise.
  - The result is purely combinational from the ALU and is sampled at the same edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, ovf<=0.
  - Next state is RUN if op_b!=0, else DONE.
  - start=0: stay in IDLE.
- RUN, one iteration per cycle:
  - acc <= alu_result; mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - ovf sticky-set if (mplier[0] & alu_carry_out) | (mcand[WIDTH-1] & (mplier>>1)!=0).
  - Exit to DONE when (mplier>>1)==0 or cnt==WIDTH-1.
- DONE:
  - done=1 for exactly one cycle; product and mul_ovf present the final acc and ovf.
  - Next state IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- Latency from the accept edge to the done pulse is k+1 cycles, where k = index of the highest set bit of op_b plus 1 (k=0 for op_b=0). Maximum 65 cycles.
- product/mul_ovf registers update only on entry to DONE.
- Arithmetic is unsigned modulo 2^WIDTH. op_a=0 still iterates k cycles.
- Throughput: a new start may be accepted in the cycle after the done pulse (IDLE).

Test Plan:
- Reset, then op_a=3, op_b=5, start one cycle -> busy for 3 cycles, done pulse on the 4th cycle after accept, product=15, mul_ovf=0; alu_cntrl=3'b010 and alu_b alternates 3, 0, 12.
- op_a=0x1234, op_b=0, start -> no RUN cycle; done on the 1st cycle after accept; product=0, mul_ovf=0.
- op_a=0xFFFFFFFFFFFFFFFF, op_b=0xFFFFFFFFFFFFFFFF -> 64 RUN cycles, product=0x0000000000000001, mul_ovf=1.
- op_a=0x8000000000000000, op_b=2 -> product=0, mul_ovf=1. Then op_a=0x4000000000000000, op_b=2 -> product=0x8000000000000000, mul_ovf=0.
- Assert start again during RUN with different operands -> ignored; first product is unchanged. Assert reset mid-RUN -> busy=0, done never pulses, product=0 next cycle. A new start afterwards runs normally.
- Random 200 operand pairs against the reference op_a*op_b (low 64 bits, overflow = upper 64 bits != 0), with latency checked equal to k+1.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows the shared execute-stage ALU.
// Computes the low WIDTH bits of op_a*op_b, one ALU add per cycle, and
// stops early once no multiplier bits remain.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, op_a, op_b     request and operands (sampled only in IDLE)
//   busy                  high while iterating (RUN)
//   done                  one-cycle completion pulse (DONE)
//   product, mul_ovf      result and overflow flag, held until next accept
//   alu_a, alu_b,         drive to the shared ALU inputs
//   alu_cntrl
//   alu_result,           returned ALU sum and carry
//   alu_carry_out
module alu_mul_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             mul_ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out
);

    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic               mul_ovf_q, mul_ovf_d;
    logic [WIDTH-1:0]   mplier_rest;

    // Multiplier bits still to be consumed after this iteration.
    assign mplier_rest = mplier_q >> 1;

    // ALU drive: accumulator plus the current partial product.
    assign alu_cntrl = ALU_ADD;
    assign alu_a     = acc_q;
    assign alu_b     = (state_q == ST_RUN && mplier_q[0]) ? mcand_q : '0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign mul_ovf = mul_ovf_q;

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        product_d = product_q;
        mul_ovf_d = mul_ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = (op_b != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_rest;
                cnt_d    = cnt_q + CNT_W'(1);
                // Overflow: carry out of this add, or a multiplicand bit
                // shifted out while higher multiplier bits are still pending.
                ovf_d    = ovf_q
                         | (mplier_q[0] & alu_carry_out)
                         | (mcand_q[WIDTH-1] & (mplier_rest != '0));
                if (mplier_rest == '0 || cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);

        // Result registers load only on entry to DONE.
        if (state_q != ST_DONE && state_d == ST_DONE) begin
            product_d = acc_d;
            mul_ovf_d = ovf_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            mul_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            mul_ovf_q <= mul_ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] op_a, op_b;
    logic        busy, done, mul_ovf;
    logic [63:0] product, alu_a, alu_b, alu_result;
    logic [2:0]  alu_cntrl;
    logic        alu_carry_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: ADD with carry out.
    assign {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_mul_seq #(.WIDTH(64), .CNT_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .mul_ovf      (mul_ovf),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cntrl    (alu_cntrl),
        .alu_result   (alu_result),
        .alu_carry_out(alu_carry_out)
    );

    function automatic int kof(input logic [63:0] b);
        int k = 0;
        for (int j = 0; j < 64; j++) if (b[j]) k = j + 1;
        return k;
    endfunction

    // Drive one request and wait (bounded) for done; lat counts negedges after accept.
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                           output int lat, output logic [63:0] p, output logic ov);
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        p  = product;
        ov = mul_ovf;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, mul_ovf} !== 3'b000 || product !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b ovf=%b product=%h, required all 0",
                     busy, done, mul_ovf, product);
        end
        n_vec++;
        if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_cntrl !== 3'b010) begin
            n_err++;
            $display("FAIL reset_alu: a=%h b=%h cntrl=%b, required 0 0 010", alu_a, alu_b, alu_cntrl);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] exp_b [3];
        exp_b[0] = 64'd3; exp_b[1] = 64'd0; exp_b[2] = 64'd12;
        @(negedge clk);
        op_a = 64'd3; op_b = 64'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || alu_b !== exp_b[i] || alu_cntrl !== 3'b010) begin
                n_err++;
                $display("FAIL basic_run%0d: busy=%b done=%b alu_b=%h cntrl=%b, required 1 0 %h 010",
                         i, busy, done, alu_b, alu_cntrl, exp_b[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== 64'd15 || mul_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: done=%b busy=%b product=%h ovf=%b, required 1 0 f 0",
                     done, busy, product, mul_ovf);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || product !== 64'd15) begin
            n_err++;
            $display("FAIL basic_hold: done=%b product=%h, required 0 f", done, product);
        end
    endtask

    task automatic test_zero_b();
        int lat; logic [63:0] p; logic ov;
        run_mul(64'h1234, 64'd0, lat, p, ov);
        n_vec++;
        if (lat !== 1 || p !== 64'd0 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL zero_b: lat=%0d product=%h ovf=%b, required 1 0 0", lat, p, ov);
        end
    endtask

    task automatic test_all_ones();
        int lat; logic [63:0] p; logic ov;
        run_mul('1, '1, lat, p, ov);
        n_vec++;
        if (lat !== 65 || p !== 64'd1 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL all_ones: lat=%0d product=%h ovf=%b, required 65 1 1", lat, p, ov);
        end
    endtask

    task automatic test_ovf_boundary();
        int lat; logic [63:0] p; logic ov;
        run_mul(64'h8000_0000_0000_0000, 64'd2, lat, p, ov);
        n_vec++;
        if (lat !== 3 || p !== 64'd0 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_lost_bit: lat=%0d product=%h ovf=%b, required 3 0 1", lat, p, ov);
        end
        run_mul(64'h4000_0000_0000_0000, 64'd2, lat, p, ov);
        n_vec++;
        if (lat !== 3 || p !== 64'h8000_0000_0000_0000 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_fits: lat=%0d product=%h ovf=%b, required 3 8000000000000000 0", lat, p, ov);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        op_a = 64'd3; op_b = 64'd5; start = 1'b1;
        @(negedge clk);
        op_a = 64'd7; op_b = 64'd9;  // second request lands in RUN
        lat = 1;
        @(negedge clk);
        start = 1'b0; lat++;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 4 || product !== 64'd15 || mul_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored: lat=%0d product=%h ovf=%b, required 4 f 0", lat, product, mul_ovf);
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_not_queued: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int lat; int seen; logic [63:0] p; logic ov;
        @(negedge clk);
        op_a = '1; op_b = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || mul_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b product=%h ovf=%b, required 0 0 0 0",
                     busy, done, product, mul_ovf);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_done: %0d cycles with busy/done, required 0", seen);
        end
        run_mul(64'd6, 64'd7, lat, p, ov);
        n_vec++;
        if (lat !== 4 || p !== 64'd42 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL after_abort: lat=%0d product=%h ovf=%b, required 4 2a 0", lat, p, ov);
        end
    endtask

    task automatic test_random();
        int lat; logic [63:0] p; logic ov;
        logic [63:0] a, b;
        logic [127:0] full;
        for (int i = 0; i < 200; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            a = a >> $urandom_range(0, 63);
            b = b >> $urandom_range(0, 63);
            if (i % 25 == 0) b = '0;
            full = {64'd0, a} * {64'd0, b};
            run_mul(a, b, lat, p, ov);
            n_vec++;
            if (p !== full[63:0] || ov !== (|full[127:64])) begin
                n_err++;
                $display("FAIL rand%0d_result: a=%h b=%h product=%h ovf=%b, required %h %b",
                         i, a, b, p, ov, full[63:0], |full[127:64]);
            end
            n_vec++;
            if (lat !== kof(b) + 1) begin
                n_err++;
                $display("FAIL rand%0d_latency: b=%h lat=%0d, required %0d", i, b, lat, kof(b) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_b();
        test_all_ones();
        test_ovf_boundary();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
